// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a first-word-fall-through receive FIFO.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   ready      in   consumer takes data this cycle (ignored while empty)
//   valid      out  FIFO not empty, data holds the oldest byte
//   data       out  FIFO head, LSB-aligned, unused upper bits zero
//   count      out  FIFO occupancy, 0..FIFO_DEPTH
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   parity_err out  one-cycle pulse, parity mismatch
//   overrun    out  sticky, a good byte was dropped on a full FIFO
//
// Build option: define UART_RX_FIFO_MAJORITY_EN to take every bit sample as
// the 2-of-3 majority around the sample point instead of a single sample.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a falling edge
// S_START  | timing to mid start bit, rejects false starts
// S_DATA   | sampling data bits, LSB first
// S_PARITY | sampling the parity bit
// S_STOP   | sampling the stop bit, deciding push / error
// S_BREAK  | stop bit was low, waiting for the line to return high

module uart_rx_fifo #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          ready,
  output logic                          valid,
  output logic [7:0]                    data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic rx_s1, rx_s2, rx_d1, rx_d2;
  logic fall, samp, tick;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [7:0] byte_w;
  logic par_bad;
  logic push_q, push_nxt, ferr_nxt, perr_nxt;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, full, wr_en;

  // Two synchroniser flops followed by a two-deep history. The sample point is
  // rx_d1, so rx_d2 / rx_s2 are the clocks before and after it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d1 <= rx_s2;
      rx_d2 <= rx_d1;
    end
  end

  assign fall = rx_d2 & ~rx_d1;
  assign tick = (cnt == '0);

`ifdef UART_RX_FIFO_MAJORITY_EN
  assign samp = (rx_s2 & rx_d1) | (rx_s2 & rx_d2) | (rx_d1 & rx_d2);
`else
  assign samp = rx_d1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      push_q     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      push_q     <= push_nxt;
      frame_err  <= ferr_nxt;
      parity_err <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    push_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START:  if (tick) state_nxt = samp ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_cnt == LAST_BIT)
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP: begin
        if (tick) begin
          if (!samp) begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end else if (par_bad) begin
            perr_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            push_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK:  if (rx_d1) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bit timer: half a bit from the falling edge to mid start, then one full
  // bit per sample. It free-runs in S_BREAK, which is harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (fall) cnt <= CNT_HALF;
      end else if (tick) begin
        cnt <= CNT_FULL;
      end else begin
        cnt <= cnt - CNT_ONE;
      end

      if (tick) begin
        case (state)
          S_START: begin
            bit_cnt <= '0;
            par_bad <= 1'b0;
          end
          S_DATA: begin
            shreg   <= {samp, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bad <= (^{shreg, samp}) != (PARITY == 1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    byte_w = '0;
    byte_w[DATA_BITS-1:0] = shreg;
  end

  assign pop   = valid & ready;
  assign full  = (count == DEPTH_C);
  // On a full FIFO a simultaneous pop frees the slot being written.
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push_q & full & ~pop) overrun <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= byte_w;
  end

  assign valid = (count != '0);
  assign data  = valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, 12_000_000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, 9600, serial bit rate; CPB = CLK_HZ/BIT_RATE (integer division) clocks per bit.
REQ-003 Parameter DATA_BITS, 8, data bits per frame; legal range 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
REQ-006 CLK  input  1  single system clock; all logic on rising edge.
REQ-007 RST_N  input  1  reset, synchronous, active-low.
REQ-008 RX  input  1  asynchronous serial line, idle high.
REQ-009 READY  input  1  consumer accepts DATA this cycle.
REQ-010 VALID  output  1  FIFO not empty; DATA holds oldest byte.
REQ-011 DATA  output  8  FIFO head, LSB-aligned; bits above DATA_BITS are 0.
REQ-012 COUNT  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-014 PARITY_ERR  output  1  one-cycle pulse: parity mismatch.
REQ-015 OVERRUN  output  1  sticky: a good byte was dropped because FIFO full.

Function
REQ-016 RX SHALL pass a two-flop synchroniser (flops reset to 1) before any use.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 IDLE -> START on synchronised RX falling edge; bit counter loaded for CPB/2 cycles.
REQ-019 START: at half-bit sample, RX=1 -> IDLE (false start, no error pulse); RX=0 -> DATA.
REQ-020 DATA: sample every CPB cycles, LSB first, DATA_BITS samples; then PARITY if PARITY!=0, else STOP.
REQ-021 PARITY: one sample; mismatch vs. odd/even over received data bits recorded.
REQ-022 STOP: one sample; 0 -> FRAME_ERR pulse, byte discarded, go BREAK; 1 with parity mismatch -> PARITY_ERR pulse, byte discarded, go IDLE; 1 and parity ok -> push, go IDLE.
REQ-023 BREAK SHALL wait for synchronised RX=1 before IDLE (held-low line yields exactly one FRAME_ERR).
REQ-024 Push SHALL write FIFO in the cycle after the stop sample; VALID asserts the following cycle.
REQ-025 FIFO SHALL be first-word-fall-through; pop when VALID && READY; READY ignored while empty.
REQ-026 Push when full and no pop: byte dropped, OVERRUN set, contents unchanged; push and pop same cycle when full: both succeed, COUNT unchanged.
REQ-027 Push and pop same cycle when non-full: COUNT unchanged, order preserved.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; COUNT ranges 0..FIFO_DEPTH.

Reset
REQ-029 RST_N low at a clock edge SHALL force FSM to IDLE, FIFO empty, COUNT=0, VALID=0, DATA=0, FRAME_ERR=0, PARITY_ERR=0, OVERRUN=0, synchroniser=1, regardless of frame in progress.
REQ-030 OVERRUN SHALL clear only on reset.

Configuration
REQ-031 Macro UART_RX_FIFO_MAJORITY_EN defined: each start/data/parity/stop sample SHALL be the 2-of-3 majority of synchronised RX at sample point -1, 0, +1 clocks; undefined: single sample at the sample point.

Verification
REQ-032 Defaults, 8N1 frame 0x41, READY=1 -> VALID one cycle with DATA=0x41, COUNT back to 0, no error pulses.
REQ-033 RX low pulse of 300 clocks (< CPB/2=625) -> no VALID, no FRAME_ERR, FSM in IDLE.
REQ-034 PARITY=2, frame 0x41 with parity bit 1 -> PARITY_ERR pulse, COUNT=0; same frame with parity bit 0 -> DATA=0x41.
REQ-035 Frame 0x55 with stop bit 0, RX held low 3 bit times -> exactly one FRAME_ERR; then frame 0xA5 -> DATA=0xA5.
REQ-036 FIFO_DEPTH=4, READY=0, frames 0x01..0x05 -> COUNT=4, OVERRUN=1; READY=1 -> DATA 0x01,0x02,0x03,0x04 in order.
REQ-037 RST_N low mid-DATA of frame 0x33 -> all outputs reset; next frame 0x7E -> DATA=0x7E; with macro, 1-clock glitch at data sample point -> byte still correct.
